// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one result bit per cycle through a single full-adder cell.
// Define SERIAL_ADDER_SUB_EN to enable subtraction (a - b) via the sub input.
module serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s, fa_cout;
  logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1: invert B and preset the carry.
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub;
  end
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = b;
  assign c_load     = 1'b0;
`endif

  assign fa_s     = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign fa_cout  = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    result_d = result_q;
    c_d      = c_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d = {fa_s, result_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        c_d      = fa_cout;
        if (last_bit) begin
          // c_q is the carry into the MSB on this final cycle.
          carry_d = fa_cout;
          ovf_d   = c_q ^ fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      result_q <= result_d;
      c_q      <= c_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result      = result_q;
  assign carry       = carry_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8): vector table plus handshake,
// backpressure, reset-abort and back-to-back sequences.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         sub = 1'b0;
  logic         done_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         start_ready, carry, overflow, done_valid, busy;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_miss   = 0;
  int cyc      = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .sub(sub), .result(result), .carry(carry), .overflow(overflow),
    .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic       c;
    logic       o;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!start_ready && g < 40) begin
      tick();
      g++;
    end
    chk("start_ready_wait", {31'd0, start_ready}, 32'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept(input logic [7:0] ia, input logic [7:0] ib, input logic isub);
    wait_ready();
    a = ia;
    b = ib;
    sub = isub;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int prev_acc;
    int pending;
    logic [7:0] exp_pend;
    logic [7:0] na, nb;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
    vecs[6] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
`else
    vecs[6] = '{8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0};
`endif

    // Reset state
    #1;
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].sub);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd8);
      chk($sformatf("v%0d_result", i), {24'd0, result}, {24'd0, vecs[i].res});
      chk($sformatf("v%0d_carry", i), {31'd0, carry}, {31'd0, vecs[i].c});
      chk($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].o});
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      chk($sformatf("v%0d_idle", i), {31'd0, start_ready}, 32'd1);
    end

    // Backpressure in DONE with start_valid pulsed
    accept(8'h12, 8'h34, 1'b0);
    wait_done(lat);
    for (int k = 0; k < 5; k++) begin
      a = 8'hFF;
      b = 8'hFF;
      start_valid = k[0] ? 1'b0 : 1'b1;
      tick();
      chk("bp_result", {24'd0, result}, 32'h46);
      chk("bp_carry", {31'd0, carry}, 32'd0);
      chk("bp_overflow", {31'd0, overflow}, 32'd0);
      chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
      chk("bp_done_valid", {31'd0, done_valid}, 32'd1);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("bp_release_ready", {31'd0, start_ready}, 32'd1);
    chk("bp_release_done", {31'd0, done_valid}, 32'd0);
    a = 8'h01;
    b = 8'h02;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("bp_next_accept", {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk("bp_next_latency", lat, 32'd8);
    chk("bp_next_result", {24'd0, result}, 32'h03);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    // Reset mid-RUN after 3 bits
    accept(8'hF0, 8'h0F, 1'b0);
    tick();
    tick();
    tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("arst_done_valid", {31'd0, done_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_result", {24'd0, result}, 32'd0);
    chk("arst_carry", {31'd0, carry}, 32'd0);
    chk("arst_overflow", {31'd0, overflow}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, start_ready}, 32'd1);
    accept(8'h01, 8'h01, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", lat, 32'd8);
    chk("post_rst_result", {24'd0, result}, 32'h02);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    // Back-to-back with done_ready tied high
    done_ready = 1'b1;
    prev_acc = 0;
    pending = 0;
    exp_pend = '0;
    for (int i = 0; i < 16; i++) begin
      int g;
      na = 8'($urandom_range(0, 255));
      nb = 8'($urandom_range(0, 255));
      a = na;
      b = nb;
      g = 0;
      while (!start_ready && g < 40) begin
        if (done_valid && pending != 0) begin
          chk($sformatf("b2b_result_%0d", i - 1), {24'd0, result}, {24'd0, exp_pend});
          pending = 0;
        end
        tick();
        g++;
      end
      chk("b2b_ready", {31'd0, start_ready}, 32'd1);
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      if (i > 0) chk("b2b_spacing", cyc - prev_acc, 32'd10);
      prev_acc = cyc;
      exp_pend = na + nb;
      pending = 1;
    end
    wait_done(lat);
    chk("b2b_last_result", {24'd0, result}, {24'd0, exp_pend});
    tick();
    done_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that computes one result bit per cycle through a single full-adder cell. It sits directly upstream of the full adder and drives its a/b/c_in inputs from operand shift registers. It consumes s/c_out back into a result shift register and a carry flop. Operands and results move over valid/ready handshakes; the block is the low-area add path for the multi-cycle execute unit.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- start_valid  in  1  operands presented
- start_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  operand A, sampled on accept
- b  in  WIDTH  operand B, sampled on accept
- sub  in  1  subtract request, sampled on accept (ignored unless SERIAL_ADDER_SUB_EN)
- result  out  WIDTH  sum/difference, valid while done_valid
- carry  out  1  carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
- overflow  out  1  two's-complement overflow
- done_valid  out  1  result available
- done_ready  in  1  consumer accepts result
- busy  out  1  high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid at a clock edge (the accept):
  - load a into shift register A and b into shift register B (B inverted when subtracting);
  - set the carry flop to 0 (1 when subtracting);
  - clear the bit counter;
  - go to RUN.
- RUN: the full-adder cell sees A[0], B[0] and the carry flop.
  - Each cycle, s shifts into result from the MSB side, A and B shift right, c_out loads the carry flop, and the counter increments.
  - When counter = WIDTH-1, go to DONE.
- During the final RUN cycle, capture overflow = (carry into bit WIDTH-1) XOR (c_out of bit WIDTH-1). Capture carry = that c_out.
- DONE: done_valid=1; result, carry and overflow are held stable.
  - On done_ready, go to IDLE.
  - start_valid is ignored (start_ready=0) until back in IDLE.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Counter width is clog2(WIDTH); it never wraps past WIDTH-1.

## Timing
- Reset (asynchronous, immediate): state IDLE, start_ready=1, done_valid=0, busy=0, result=0, carry=0, overflow=0, counter=0, shift registers=0.
- Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
- Accept at edge 0, RUN on edges 1..WIDTH, done_valid goes high after edge WIDTH.
- done_ready sampled high at edge k causes done_valid low and start_ready high after edge k.
- Earliest next accept is at edge k+1, so the minimum initiation interval is WIDTH+2 cycles.
- done_ready is ignored outside DONE.
- Outputs are registered; no combinational path from any input to any output.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub=1 on accept computes a − b: B is loaded as ~b and the carry flop is initialised to 1.
  - carry and overflow follow subtract semantics.
- Not defined:
  - sub is ignored and the operation is always a + b;
  - the B inverter and the carry-preset logic are not synthesised.

## Test plan
- WIDTH=8, a=8'h3C, b=8'h05, sub=0 -> result 8'h41, carry 0, overflow 0; done_valid rises exactly 8 cycles after accept.
- a=8'hFF, b=8'h01 -> result 8'h00, carry 1, overflow 0; a=8'h7F, b=8'h01 -> result 8'h80, carry 0, overflow 1.
- Backpressure: hold done_ready=0 for 5 cycles in DONE while pulsing start_valid -> result, carry and overflow stay stable, start_ready stays 0, no new operand is taken. Then done_ready=1 -> IDLE next cycle; the next accept is one cycle later.
- SERIAL_ADDER_SUB_EN: a=8'h05, b=8'h07, sub=1 -> result 8'hFE, carry 0, overflow 0; a=8'h80, b=8'h01, sub=1 -> result 8'h7F, carry 1, overflow 1. Without the macro the same stimulus gives 8'h0C and 8'h81.
- rst_n low during RUN after 3 bits -> all outputs go to their reset values immediately. After release, start_ready=1 and a fresh a=8'h01, b=8'h01 gives 8'h02.
- Back-to-back: 16 random operand pairs with done_ready tied high -> every result matches a+b mod 256, and accepts are spaced exactly 10 cycles apart.
